// File: rtl/traffic_gen.sv
// traffic_gen: CPU-port traffic generator (seq/random/fixed/seq-down addressing, read/write mixes).
// Define TGEN_CHECK_EN to add a shadow-memory read-back checker.
module traffic_gen #(
  parameter int          ADDR_WIDTH = 11,
  parameter int          DATA_WIDTH = 8,
  parameter int          REQ_HOLD   = 2,
  parameter int          STRIDE     = 2,
  parameter int          TIMEOUT    = 1024,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           num_req,
  input  logic [1:0]            addr_mode,
  input  logic [1:0]            rw_mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_read,
  output logic                  cpu_write,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  input  logic                  cpu_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t                state_q, state_d;
  logic [15:0]           idx_q, idx_d, hold_q, hold_d, lfsr_q, lfsr_d, num_q, nidx;
  logic [ADDR_WIDTH-1:0] off_q, off_d, addr_q, addr_d, base_q, noff, req_addr;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  logic [1:0]            am_q, rm_q, cfg_am, cfg_rm;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic                  rd_q, rd_d, wr_q, wr_d, to_q, to_d, is_wr_q, is_wr_d;
  logic                  issue, clr, req_wr, done_req;
  logic [15:0]           lfsr_nx;
  // The first request is built in the same cycle start is seen, so IDLE reads the live inputs.
  assign cfg_am   = (state_q == S_IDLE) ? addr_mode : am_q;
  assign cfg_rm   = (state_q == S_IDLE) ? rw_mode : rm_q;
  assign cfg_base = (state_q == S_IDLE) ? base_addr : base_q;
  assign lfsr_nx  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign done_req = (state_q == S_WAIT) && cpu_ready;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    hold_d  = hold_q;
    wcnt_d  = wcnt_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    to_d    = to_q;
    is_wr_d = is_wr_q;
    issue   = 1'b0;
    clr     = 1'b0;
    nidx    = idx_q;
    noff    = off_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = (num_req == 16'd0) ? S_DONE : S_ISSUE;
        issue   = (num_req != 16'd0);
        clr     = (num_req != 16'd0);
        to_d    = (num_req != 16'd0) ? 1'b0 : to_q;
        nidx    = 16'd0;
        noff    = '0;
      end
      S_ISSUE: begin
        hold_d = hold_q + 16'd1;
        if (hold_q == 16'(REQ_HOLD - 1)) begin
          state_d = S_WAIT;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (cpu_ready) begin
          // Write-then-read keeps the same address for the paired read.
          noff  = (cfg_rm != 2'd1 || idx_q[0]) ? off_q + ADDR_WIDTH'(STRIDE) : off_q;
          off_d = noff;
          nidx  = idx_q + 16'd1;
          issue = ({1'b0, idx_q} + 17'd1) < {1'b0, num_q};
          state_d = issue ? S_ISSUE : S_DONE;
        end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_addr = (cfg_rm == 2'd1 && nidx[0]) ? addr_q :
               (cfg_am == 2'd0) ? cfg_base + noff :
               (cfg_am == 2'd1) ? ADDR_WIDTH'(lfsr_q) :
               (cfg_am == 2'd2) ? cfg_base : cfg_base - noff;
    req_wr   = (cfg_rm == 2'd3) || (cfg_rm == 2'd1 && !nidx[0]) || (cfg_rm == 2'd2 && lfsr_q[15]);
    if (issue) begin
      idx_d   = nidx;
      off_d   = noff;
      hold_d  = 16'd0;
      lfsr_d  = lfsr_nx;
      addr_d  = req_addr;
      din_d   = DATA_WIDTH'(nidx) ^ DATA_WIDTH'(req_addr);
      wr_d    = req_wr;
      rd_d    = !req_wr;
      is_wr_d = req_wr;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      hold_q  <= '0;
      wcnt_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
      is_wr_q <= 1'b0;
      am_q    <= '0;
      rm_q    <= '0;
      base_q  <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      hold_q  <= hold_d;
      wcnt_q  <= wcnt_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      to_q    <= to_d;
      is_wr_q <= is_wr_d;
      if (state_q == S_IDLE && start) begin
        am_q   <= addr_mode;
        rm_q   <= rw_mode;
        base_q <= base_addr;
        num_q  <= num_req;
      end
    end
  end
  assign cpu_addr    = addr_q;
  assign cpu_data_in = din_q;
  assign cpu_read    = rd_q;
  assign cpu_write   = wr_q;
  assign busy        = state_q != S_IDLE;
  assign done        = state_q == S_DONE;
  assign timeout     = to_q;
`ifdef TGEN_CHECK_EN
  logic [DATA_WIDTH-1:0]    shadow [2**ADDR_WIDTH];
  logic [2**ADDR_WIDTH-1:0] valid_q;
  logic [15:0]              err_q;
  logic [ADDR_WIDTH-1:0]    ferr_q;
  logic                     mism;
  assign mism = done_req && !is_wr_q && valid_q[addr_q] && (shadow[addr_q] != cpu_data_out);
  always_ff @(posedge clk) begin
    if (done_req && is_wr_q) shadow[addr_q] <= din_q;
  end
  // Valid bits survive across runs so later runs can check earlier writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
    end else begin
      if (done_req && is_wr_q) valid_q[addr_q] <= 1'b1;
      if (clr) begin
        err_q  <= '0;
        ferr_q <= '0;
      end else if (mism) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (err_q == 16'd0) ferr_q <= addr_q;
      end
    end
  end
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
`else
  logic unused_ok;
  assign unused_ok      = ^{cpu_data_out, is_wr_q, done_req, clr};
  assign err_count      = '0;
  assign first_err_addr = '0;
`endif
endmodule

// File: tb/tb_traffic_gen.sv
// tb_traffic_gen: scoreboard bench for traffic_gen; stimulus pushes expected requests, a monitor pops them.
module tb_traffic_gen;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] num_req = '0;
  logic [1:0]  addr_mode = '0, rw_mode = '0;
  logic [10:0] base_addr = '0, cpu_addr, first_err_addr;
  logic [7:0]  cpu_data_in, cpu_data_out;
  logic        cpu_read, cpu_write, cpu_ready, busy, done, timeout;
  logic [15:0] err_count;
  int checks = 0, errors = 0;
  typedef struct {logic [10:0] a; logic w; logic [7:0] d;} req_t;
  req_t q[$];
  logic       resp_never = 1'b0;
  logic [7:0] resp_xor = 8'h00;
  always #5 clk = ~clk;
  traffic_gen #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_req(num_req), .addr_mode(addr_mode),
    .rw_mode(rw_mode), .base_addr(base_addr), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .busy(busy), .done(done), .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [10:0] a, input logic w, input int idx);
    q.push_back('{a, w, 8'(idx) ^ a[7:0]});
  endtask
  // Responder: completes each request 3 cycles after it drops, backed by a small memory.
  logic [7:0]  rmem [2048];
  int          r_cnt = 0;
  logic [10:0] r_a;
  logic        r_w;
  logic [7:0]  r_d;
  initial begin
    cpu_ready = 1'b0;
    cpu_data_out = '0;
    for (int i = 0; i < 2048; i++) rmem[i] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cpu_ready = 1'b0;
      if (!rst_n) r_cnt = 0;
      else if (cpu_read || cpu_write) begin
        r_cnt = 3;
        r_a = cpu_addr;
        r_w = cpu_write;
        r_d = cpu_data_in;
      end else if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0 && !resp_never) begin
          cpu_ready = 1'b1;
          if (r_w) rmem[r_a] = r_d;
          else cpu_data_out = rmem[r_a] ^ resp_xor;
        end
      end
    end
  end
  logic m_prev = 1'b0;
  int   m_hl = 0;
  req_t m_e;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_prev = 1'b0;
      m_hl = 0;
    end else begin
      if ((cpu_read || cpu_write) && !m_prev) begin
        m_hl = 1;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: addr %0h read %0b write %0b with nothing expected", cpu_addr, cpu_read, cpu_write);
        end else begin
          m_e = q.pop_front();
          chk("req_addr", cpu_addr, m_e.a);
          chk("req_write", cpu_write, m_e.w);
          chk("req_read", cpu_read, !m_e.w);
          if (m_e.w) chk("wr_data", cpu_data_in, m_e.d);
        end
      end else if ((cpu_read || cpu_write) && m_prev) m_hl++;
      else if (m_prev) chk("hold_cycles", m_hl, 2);
      m_prev = cpu_read || cpu_write;
    end
  end
  task automatic kick(input logic [1:0] am, input logic [1:0] rm, input logic [10:0] base, input logic [15:0] n);
    @(posedge clk);
    #1;
    addr_mode = am;
    rw_mode = rm;
    base_addr = base;
    num_req = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input logic exp_to);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no done pulse within 3000 cycles");
    end else begin
      chk("timeout_flag", timeout, exp_to);
      chk("busy_in_done", busy, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
    end
    chk("all_reqs_issued", q.size(), 0);
  endtask
  task automatic wait_fall();
    bit hi = 0, ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cpu_read || cpu_write) hi = 1;
      else if (hi) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_fall: request did not complete its hold within 200 cycles");
    end
  endtask
  task automatic push_wtr();
    for (int i = 0; i < 8; i++) push(11'h040 + 11'(2 * (i / 2)), (i % 2) == 0, i);
  endtask
  initial begin
    int wc;
    bit seen;
    @(negedge clk);
    chk("rst_read", cpu_read, 0);
    chk("rst_write", cpu_write, 0);
    chk("rst_addr", cpu_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lfsr", dut.lfsr_q, 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    // Zero-length run: done next cycle, no request.
    kick(0, 0, 0, 0);
    @(negedge clk);
    chk("zero_req_done", done, 1);
    @(negedge clk);
    chk("zero_req_done_low", done, 0);
    chk("zero_req_idle", busy, 0);
    // Sequential reads; a mid-run start with other settings must be ignored.
    for (int i = 0; i < 6; i++) push(11'(2 * i), 0, i);
    kick(0, 0, 11'h000, 6);
    repeat (6) @(posedge clk);
    #1;
    addr_mode = 2'd2;
    base_addr = 11'h100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0);
    // Write-then-read at 0x040.
    push_wtr();
    kick(0, 1, 11'h040, 8);
    wait_done(0);
    chk("wtr_err_count", err_count, 0);
    chk("wtr_first_err", first_err_addr, 0);
    // Responder corrupts read data.
    resp_xor = 8'h01;
    push_wtr();
    kick(0, 1, 11'h040, 8);
    wait_done(0);
`ifdef TGEN_CHECK_EN
    chk("fault_err_count", err_count, 4);
    chk("fault_first_err", first_err_addr, 11'h040);
`else
    chk("fault_err_count", err_count, 0);
    chk("fault_first_err", first_err_addr, 0);
`endif
    resp_xor = 8'h00;
    // Seq-down wrap, write-only.
    push(11'h002, 1, 0);
    push(11'h000, 1, 1);
    push(11'h7FE, 1, 2);
    kick(3, 3, 11'h002, 3);
    wait_done(0);
    // Fixed address reads.
    push(11'h123, 0, 0);
    push(11'h123, 0, 1);
    kick(2, 0, 11'h123, 2);
    wait_done(0);
    // Timeout: responder silent.
    resp_never = 1'b1;
    push(11'h010, 0, 0);
    kick(0, 0, 11'h010, 3);
    wait_fall();
    wc = 1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      if (!done) wc++;
    end
    chk("timeout_wait_cycles", wc, 16);
    chk("timeout_set", timeout, 1);
    @(negedge clk);
    chk("timeout_idle", busy, 0);
    chk("timeout_sticky", timeout, 1);
    chk("timeout_q_empty", q.size(), 0);
    resp_never = 1'b0;
    // Reset during the second request's WAIT.
    for (int i = 0; i < 4; i++) push(11'(2 * i), 0, i);
    kick(0, 0, 11'h000, 4);
    wait_fall();
    wait_fall();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", cpu_read, 0);
    chk("mid_rst_write", cpu_write, 0);
    chk("mid_rst_addr", cpu_addr, 0);
    chk("mid_rst_data", cpu_data_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_ferr", first_err_addr, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_quiet", busy, 0);
    // Random address, random rw from reseeded LFSR: ACE1 then E270.
    push(11'h4E1, 1, 0);
    push(11'h270, 1, 1);
    kick(1, 2, 11'h000, 2);
    wait_done(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
